// File: rtl/decode_scoreboard.sv
// Register scoreboard and issue controller for the integer decode stage.
// Optional stall-cycle counter enabled by defining SCOREBOARD_STALL_CNT_EN.
module decode_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  output logic        id_ready,
  output logic        issue,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  input  logic        drain_req,
  output logic        drained,
  output logic [31:0] busy_mask,
  output logic        err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg  [32];
  logic [CNT_W-1:0] cnt_next [32];
  logic             err_reg;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       is_r, is_i, uses_rs1, uses_rs2, writes_rd;
  logic       hazard, all_idle;

  assign opcode    = id_inst[6:0];
  assign rd        = id_inst[11:7];
  assign rs1       = id_inst[19:15];
  assign rs2       = id_inst[24:20];
  assign is_r      = (opcode == 7'b0110011);
  assign is_i      = (opcode == 7'b0010011);
  assign uses_rs1  = is_r | is_i;
  assign uses_rs2  = is_r;
  assign writes_rd = is_r | is_i;

  // Bit 0 of busy_mask is tied low, so x0 sources never hazard.
  for (genvar gi = 0; gi < 32; gi++) begin : g_busy
    if (gi == 0) begin : g_x0
      assign busy_mask[gi] = 1'b0;
    end else begin : g_xn
      assign busy_mask[gi] = |cnt_reg[gi];
    end
  end

  assign all_idle = (busy_mask == 32'd0);

  assign hazard = (uses_rs1 && busy_mask[rs1]) ||
                  (uses_rs2 && busy_mask[rs2]) ||
                  (writes_rd && (rd != 5'd0) && (cnt_reg[rd] == {CNT_W{1'b1}}));

  assign id_ready = (state_reg == RUN) && !flush && !hazard;
  assign issue    = id_valid && id_ready;
  assign drained  = (state_reg == DRAINED);
  assign err      = err_reg;

  // Simultaneous issue and retire on the same register cancel out.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_next[r] = cnt_reg[r];
      if (r != 0 && !flush) begin
        cnt_next[r] = cnt_reg[r]
                    + CNT_W'(issue && writes_rd && (rd == 5'(r)))
                    - CNT_W'(wb_valid && (wb_rd == 5'(r)) && (cnt_reg[r] != '0));
      end else begin
        cnt_next[r] = '0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (drain_req) state_next = DRAIN;
      DRAIN: begin
        if (!drain_req)    state_next = RUN;
        else if (all_idle) state_next = DRAINED;
      end
      DRAINED: if (!drain_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= RUN;
      err_reg   <= 1'b0;
      for (int r = 0; r < 32; r++) cnt_reg[r] <= '0;
    end else begin
      state_reg <= state_next;
      if (wb_valid && (wb_rd != 5'd0) && !busy_mask[wb_rd]) err_reg <= 1'b1;
      for (int r = 0; r < 32; r++) cnt_reg[r] <= cnt_next[r];
    end
  end

`ifdef SCOREBOARD_STALL_CNT_EN
  logic [15:0] stall_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_reg <= 16'd0;
    end else if (id_valid && !id_ready && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_reg;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Randomized and directed bench for decode_scoreboard; a queue-based scoreboard
// compares every cycle's outputs against a pending-write-count model.
module tb_decode_scoreboard;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        id_valid, id_ready, issue, wb_valid, flush, drain_req, drained, err;
  logic [31:0] id_inst, busy_mask;
  logic [4:0]  wb_rd;
  logic [15:0] stall_cnt;

  decode_scoreboard #(.CNT_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid), .id_inst(id_inst),
    .id_ready(id_ready), .issue(issue), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .drain_req(drain_req), .drained(drained),
    .busy_mask(busy_mask), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

`ifdef SCOREBOARD_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  localparam int MAX_PEND = 3;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;

  typedef struct {
    logic        ready;
    logic        iss;
    logic [31:0] busy;
    logic        drained;
    logic        err;
    logic [15:0] stall;
    int          idx;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   ncyc   = 0;
  int   pend[32];
  int   mode;
  int   m_stall;
  bit   m_err;
  bit   in_reset;

  function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic bit model_ready(logic [31:0] inst, bit fl);
    bit is_r, is_i, haz;
    is_r = (inst[6:0] == OP_R);
    is_i = (inst[6:0] == OP_I);
    haz  = 1'b0;
    if ((is_r || is_i) && inst[19:15] != 0 && pend[inst[19:15]] > 0) haz = 1'b1;
    if (is_r && inst[24:20] != 0 && pend[inst[24:20]] > 0) haz = 1'b1;
    if ((is_r || is_i) && inst[11:7] != 0 && pend[inst[11:7]] == MAX_PEND) haz = 1'b1;
    return (mode == M_RUN) && !fl && !haz;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int i = 1; i < 32; i++) b[i] = (pend[i] != 0);
    return b;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    mode = M_RUN; m_err = 1'b0; m_stall = 0;
  endfunction

  function automatic void model_update(bit iss, logic [31:0] inst, bit wv, logic [4:0] wr,
                                       bit fl, bit dr, bit stalled);
    int  old[32];
    bit  idle;
    bit  wr_dst;
    old    = pend;
    idle   = 1'b1;
    for (int i = 1; i < 32; i++) if (old[i] != 0) idle = 1'b0;
    wr_dst = (inst[6:0] == OP_R) || (inst[6:0] == OP_I);
    if (wv && wr != 0 && old[wr] == 0) m_err = 1'b1;
    if (STALL_EN && stalled && m_stall < 65535) m_stall++;
    case (mode)
      M_RUN:     if (dr) mode = M_DRAIN;
      M_DRAIN:   if (!dr) mode = M_RUN; else if (idle) mode = M_DRAINED;
      default:   if (!dr) mode = M_RUN;
    endcase
    if (fl) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
    end else begin
      if (wv && wr != 0 && old[wr] > 0) pend[wr]--;
      if (iss && wr_dst && inst[11:7] != 0) pend[inst[11:7]]++;
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req, int idx);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, idx, act, req);
    end
  endtask

  // One cycle: drive at posedge+1, queue expectation, model advances on the edge.
  task automatic step(input bit v, input logic [31:0] inst, input bit wv, input logic [4:0] wr,
                      input bit fl, input bit dr, output bit iss);
    exp_t e;
    bit   rdy;
    id_valid = v; id_inst = inst; wb_valid = wv; wb_rd = wr; flush = fl; drain_req = dr;
    rdy       = model_ready(inst, fl);
    iss       = v && rdy;
    e.ready   = rdy;
    e.iss     = iss;
    e.busy    = model_busy();
    e.drained = (mode == M_DRAINED);
    e.err     = m_err;
    e.stall   = 16'(m_stall);
    e.idx     = ncyc;
    expq.push_back(e);
    $display("cyc %0d v=%0b inst=%08h wb=%0b/%0d fl=%0b dr=%0b exp_ready=%0b", ncyc, v, inst, wv, wr, fl, dr, rdy);
    @(posedge CLK);
    if (!in_reset) model_update(iss, inst, wv, wr, fl, dr, v && !rdy);
    ncyc++;
    #1;
  endtask

  task automatic reset_mid();
    bit d;
    RST_N = 1'b0; in_reset = 1'b1;
    model_reset();
    step(0, 32'd0, 0, 5'd0, 0, 0, d);
    RST_N = 1'b1; in_reset = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("id_ready",  32'(id_ready),  32'(e.ready),   e.idx);
      chk("issue",     32'(issue),     32'(e.iss),     e.idx);
      chk("busy_mask", busy_mask,      e.busy,         e.idx);
      chk("drained",   32'(drained),   32'(e.drained), e.idx);
      chk("err",       32'(err),       32'(e.err),     e.idx);
      chk("stall_cnt", 32'(stall_cnt), 32'(e.stall),   e.idx);
    end
  end

  initial begin
    bit          d;
    bit          v, wv, fl, dr, prev_stall;
    logic [31:0] inst;
    logic [4:0]  wr;
    int          cands[$];

    RST_N = 1'b0; in_reset = 1'b1;
    id_valid = 0; id_inst = 0; wb_valid = 0; wb_rd = 0; flush = 0; drain_req = 0;
    model_reset();
    @(posedge CLK); #1;
    step(0, 32'd0, 0, 5'd0, 0, 0, d);
    step(0, 32'd0, 0, 5'd0, 0, 0, d);
    RST_N = 1'b1; in_reset = 1'b0;

    // RAW stall on x5, released the cycle after its writeback
    step(1, 32'h002082B3, 0, 5'd0, 0, 0, d);
    repeat (3) step(1, 32'h00128313, 0, 5'd0, 0, 0, d);
    step(1, 32'h00128313, 1, 5'd5, 0, 0, d);
    step(1, 32'h00128313, 0, 5'd0, 0, 0, d);
    step(0, 32'd0, 1, 5'd6, 0, 0, d);

    // Saturation of x7
    repeat (3) step(1, mk(OP_I, 5'd7, 5'd0, 5'd0), 0, 5'd0, 0, 0, d);
    step(1, mk(OP_I, 5'd7, 5'd0, 5'd0), 0, 5'd0, 0, 0, d);
    step(1, mk(OP_I, 5'd7, 5'd0, 5'd0), 1, 5'd7, 0, 0, d);
    step(1, mk(OP_I, 5'd7, 5'd0, 5'd0), 0, 5'd0, 0, 0, d);
    step(1, mk(OP_I, 5'd7, 5'd0, 5'd0), 1, 5'd7, 0, 0, d);
    step(1, mk(OP_I, 5'd7, 5'd0, 5'd0), 1, 5'd7, 0, 0, d);
    repeat (3) step(0, 32'd0, 1, 5'd7, 0, 0, d);

    // x0 and non-ALU opcodes
    step(1, 32'h00000013, 0, 5'd0, 0, 0, d);
    step(1, mk(7'b1101111, 5'd1, 5'd7, 5'd7), 0, 5'd0, 0, 0, d);
    step(1, 32'h00000013, 1, 5'd0, 0, 0, d);
    step(0, 32'd0, 0, 5'd0, 0, 0, d);

    // Underflow is sticky through flush, cleared by reset
    step(0, 32'd0, 1, 5'd9, 0, 0, d);
    step(0, 32'd0, 0, 5'd0, 1, 0, d);
    step(0, 32'd0, 0, 5'd0, 0, 0, d);
    reset_mid();
    step(0, 32'd0, 0, 5'd0, 0, 0, d);

    // Drain with x3 and x4 pending
    step(1, mk(OP_I, 5'd3, 5'd0, 5'd0), 0, 5'd0, 0, 0, d);
    step(1, mk(OP_I, 5'd4, 5'd0, 5'd0), 0, 5'd0, 0, 0, d);
    step(1, mk(OP_R, 5'd8, 5'd1, 5'd2), 0, 5'd0, 0, 1, d);
    step(1, mk(OP_R, 5'd8, 5'd1, 5'd2), 1, 5'd3, 0, 1, d);
    step(1, mk(OP_R, 5'd8, 5'd1, 5'd2), 1, 5'd4, 0, 1, d);
    repeat (2) step(1, mk(OP_R, 5'd8, 5'd1, 5'd2), 0, 5'd0, 0, 1, d);
    step(1, mk(OP_R, 5'd8, 5'd1, 5'd2), 0, 5'd0, 0, 0, d);
    step(1, mk(OP_R, 5'd8, 5'd1, 5'd2), 0, 5'd0, 0, 0, d);
    step(0, 32'd0, 1, 5'd8, 0, 0, d);

    // Flush with x1..x10 pending, colliding with issue and writeback
    for (int r = 1; r <= 10; r++) step(1, mk(OP_I, 5'(r), 5'd0, 5'd0), 0, 5'd0, 0, 0, d);
    step(1, mk(OP_I, 5'd11, 5'd0, 5'd0), 1, 5'd1, 1, 0, d);
    step(0, 32'd0, 0, 5'd0, 0, 0, d);

    // Reset in the middle of a drain
    step(1, mk(OP_I, 5'd3, 5'd0, 5'd0), 0, 5'd0, 0, 0, d);
    step(1, mk(OP_I, 5'd3, 5'd0, 5'd0), 0, 5'd0, 0, 1, d);
    step(1, mk(OP_I, 5'd3, 5'd0, 5'd0), 0, 5'd0, 0, 1, d);
    reset_mid();
    step(1, mk(OP_I, 5'd3, 5'd0, 5'd0), 0, 5'd0, 0, 0, d);

    // Randomized traffic; writebacks only retire registers that are pending
    v = 0; inst = 0; dr = 0; prev_stall = 0;
    for (int n = 0; n < 800; n++) begin
      if (!prev_stall) begin
        int k;
        logic [6:0] op;
        k  = $urandom_range(0, 4);
        op = (k < 2) ? OP_R : (k < 4) ? OP_I : 7'b0000011;
        v    = ($urandom_range(0, 99) < 70);
        inst = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      cands.delete();
      for (int r = 1; r < 32; r++) if (pend[r] > 0) cands.push_back(r);
      wv = (cands.size() != 0) && ($urandom_range(0, 99) < 45);
      wr = wv ? 5'(cands[$urandom_range(0, cands.size() - 1)]) : 5'd0;
      fl = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 5) dr = !dr;
      if ($urandom_range(0, 999) < 4) begin
        reset_mid();
        prev_stall = 0;
        continue;
      end
      step(v, inst, wv, wr, fl, dr, d);
      prev_stall = v && !d;
    end

    step(0, 32'd0, 0, 5'd0, 0, 0, d);
    repeat (2) @(posedge CLK);
    chk("queue_empty", 32'(expq.size()), 32'd0, ncyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
